rr_stream_multiplexer: RTL and testbench

- Merges N_STREAMS independent valid/ready streams into one output stream using round-robin arbitration.
- The output is registered and tagged with the index of the source stream.
- It is the companion stage to the stream demultiplexer. It sits directly upstream of it, so the o_stream tag can drive the demux stream_select and route completions back to the originating requester.
- With LOCK_ON_LAST=1, packets of multiple beats from one source are never interleaved with beats from another source.

---
 rtl/rr_stream_multiplexer.sv | 151 +++++++++++++++
 tb/tb_rr_stream_multiplexer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_multiplexer.sv
// -----------------------------------------------------------------------------
// rr_stream_multiplexer
//
// Merges N_STREAMS valid/ready input streams into one registered output
// stream using round-robin arbitration. Each output beat is tagged with the
// index of the stream it came from, so a downstream demultiplexer can route
// responses back to the requester. With LOCK_ON_LAST=1 a multi-beat packet
// keeps the grant until its i_last beat is accepted, so packets from
// different sources are never interleaved.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   i_data    payload per input stream
//   i_valid   valid per input stream
//   i_last    end-of-packet marker per input stream
//   i_ready   ready per input stream (combinational; only the grantee is high)
//   o_data    merged payload (registered)
//   o_valid   merged valid (registered)
//   o_last    last flag of the forwarded beat (registered)
//   o_stream  source index of the current output beat (registered)
//   o_ready   downstream ready
// -----------------------------------------------------------------------------
module rr_stream_multiplexer #(
    parameter int  N_STREAMS    = 2,
    parameter type DATA_TYPE    = logic [63:0],
    parameter bit  LOCK_ON_LAST = 1'b1,
    localparam int N_BITS       = (N_STREAMS > 32'sd1) ? $clog2(N_STREAMS) : 32'sd1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  DATA_TYPE             i_data [N_STREAMS],
    input  logic [N_STREAMS-1:0] i_valid,
    input  logic [N_STREAMS-1:0] i_last,
    output logic [N_STREAMS-1:0] i_ready,
    output DATA_TYPE             o_data,
    output logic                 o_valid,
    output logic                 o_last,
    output logic [N_BITS-1:0]    o_stream,
    input  logic                 o_ready
);

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [N_BITS-1:0] rr_ptr_r;
    logic [N_BITS-1:0] rr_ptr_s;
    logic [N_BITS-1:0] lock_idx_r;
    logic [N_BITS-1:0] lock_idx_s;
    logic [N_BITS-1:0] grant_s;
    logic              grant_vld_s;
    logic              load_s;
    logic              accept_s;
    int                cand_s;

    // The output register can take a new beat when it is empty or being drained.
    assign load_s   = !o_valid | o_ready;
    assign accept_s = load_s & grant_vld_s;

    // Grant selection: locked stream, or first valid stream at or after rr_ptr.
    always_comb begin
        grant_s     = lock_idx_r;
        grant_vld_s = 1'b0;
        cand_s      = 32'sd0;
        case (state_r)
            LOCKED: begin
                grant_s     = lock_idx_r;
                grant_vld_s = i_valid[lock_idx_r];
            end
            ARB: begin
                // Walk offsets from farthest to nearest so the nearest valid
                // stream (in wrap-around order) is the one left standing.
                for (int i = N_STREAMS - 32'sd1; i >= 32'sd0; i--) begin
                    cand_s      = int'(rr_ptr_r) + i;
                    cand_s      = (cand_s >= N_STREAMS) ? (cand_s - N_STREAMS) : cand_s;
                    grant_s     = i_valid[cand_s] ? N_BITS'(cand_s) : grant_s;
                    grant_vld_s = i_valid[cand_s] | grant_vld_s;
                end
            end
            default: begin
                grant_s     = lock_idx_r;
                grant_vld_s = 1'b0;
            end
        endcase
    end

    // Ready goes only to the grantee, and is forced low while reset is held.
    always_comb begin
        i_ready          = {N_STREAMS{1'b0}};
        i_ready[grant_s] = rst_n & load_s & grant_vld_s;
    end

    // Next arbitration state: lock on a non-last beat, otherwise advance rr_ptr.
    always_comb begin
        state_s    = state_r;
        rr_ptr_s   = rr_ptr_r;
        lock_idx_s = lock_idx_r;
        if (accept_s) begin
            if ((LOCK_ON_LAST == 1'b1) && !i_last[grant_s]) begin
                state_s    = LOCKED;
                lock_idx_s = grant_s;
            end else begin
                state_s  = ARB;
                rr_ptr_s = (grant_s == N_BITS'(N_STREAMS - 32'sd1)) ? {N_BITS{1'b0}}
                                                                   : grant_s + N_BITS'(32'd1);
            end
        end else begin
            state_s = state_r;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ARB;
            rr_ptr_r   <= {N_BITS{1'b0}};
            lock_idx_r <= {N_BITS{1'b0}};
        end else begin
            state_r    <= state_s;
            rr_ptr_r   <= rr_ptr_s;
            lock_idx_r <= lock_idx_s;
        end
    end

    // Output register: load the granted beat, or empty out when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data   <= DATA_TYPE'('0);
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            o_stream <= {N_BITS{1'b0}};
        end else if (load_s) begin
            if (accept_s) begin
                o_data   <= i_data[grant_s];
                o_valid  <= 1'b1;
                o_last   <= i_last[grant_s];
                o_stream <= grant_s;
            end else begin
                // Payload, last and tag keep their last values while empty.
                o_valid <= 1'b0;
            end
        end else begin
            o_valid <= o_valid;
        end
    end

endmodule

// File: tb/tb_rr_stream_multiplexer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for rr_stream_multiplexer (N_STREAMS=4,
// LOCK_ON_LAST=1). Inputs change 1 time unit after the rising edge; registered
// outputs are sampled at that same point, combinational i_ready 1 unit later.
// -----------------------------------------------------------------------------
module tb_rr_stream_multiplexer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] i_data [N];
    logic [N-1:0] i_valid;
    logic [N-1:0] i_last;
    logic [N-1:0] i_ready;
    logic [63:0] o_data;
    logic        o_valid;
    logic        o_last;
    logic [1:0]  o_stream;
    logic        o_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_stream_multiplexer #(
        .N_STREAMS    (N),
        .DATA_TYPE    (logic [63:0]),
        .LOCK_ON_LAST (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .i_last   (i_last),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_last   (o_last),
        .o_stream (o_stream),
        .o_ready  (o_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every stream valid: i_ready must still be all zero.
        rst_n   = 1'b0;
        o_ready = 1'b1;
        i_valid = 4'hF;
        i_last  = 4'hF;
        for (int k = 0; k < N; k++) i_data[k] = 64'h100 + 64'(k);
        tick();
        tick();
        chk("rst_o_valid",  64'(o_valid),  64'h0);
        chk("rst_o_stream", 64'(o_stream), 64'h0);
        chk("rst_o_data",   o_data,        64'h0);
        chk("rst_o_last",   64'(o_last),   64'h0);
        chk("rst_i_ready",  64'(i_ready),  64'h0);

        // Round robin over four always-valid single-beat streams.
        rst_n = 1'b1;
        #1;
        chk("rr_first_ready", 64'(i_ready), 64'h1);
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("rr_o_stream", 64'(o_stream), 64'(j % 4));
            chk("rr_o_valid",  64'(o_valid),  64'h1);
            chk("rr_o_data",   o_data,        64'h100 + 64'(j % 4));
            chk("rr_i_ready",  64'(i_ready),  64'(4'b0001 << ((j + 1) % 4)));
        end

        // Wrap-around: grant 2 leaves rr_ptr=3; then streams 0 and 3 compete.
        i_valid = 4'b0100;
        #1;
        chk("wrap_pre_ready", 64'(i_ready), 64'h4);
        tick();
        chk("wrap_pre_stream", 64'(o_stream), 64'h2);
        i_valid = 4'b1001;
        #1;
        chk("wrap_first_ready", 64'(i_ready), 64'h8);
        tick();
        chk("wrap_first_stream", 64'(o_stream), 64'h3);
        chk("wrap_second_ready", 64'(i_ready), 64'h1);
        tick();
        chk("wrap_second_stream", 64'(o_stream), 64'h0);
        i_valid = 4'b0000;
        tick();
        chk("idle_o_valid",  64'(o_valid),  64'h0);
        chk("idle_o_stream", 64'(o_stream), 64'h0);
        chk("idle_o_data",   o_data,        64'h100);

        // Lock: stream 1 sends a 3-beat packet with a 2-cycle gap, stream 0 waits.
        i_valid   = 4'b0011;
        i_last    = 4'b1101;
        i_data[1] = 64'hB1;
        #1;
        chk("lock_b1_ready", 64'(i_ready), 64'h2);
        tick();
        chk("lock_b1_stream", 64'(o_stream), 64'h1);
        chk("lock_b1_last",   64'(o_last),   64'h0);
        chk("lock_b1_data",   o_data,        64'hB1);
        i_valid = 4'b0001;
        #1;
        chk("gap_ready", 64'(i_ready), 64'h0);
        tick();
        chk("gap1_o_valid", 64'(o_valid), 64'h0);
        tick();
        chk("gap2_o_valid", 64'(o_valid), 64'h0);
        chk("gap2_ready",   64'(i_ready), 64'h0);
        i_valid   = 4'b0011;
        i_data[1] = 64'hB2;
        #1;
        chk("lock_b2_ready", 64'(i_ready), 64'h2);
        tick();
        chk("lock_b2_stream", 64'(o_stream), 64'h1);
        chk("lock_b2_valid",  64'(o_valid),  64'h1);
        chk("lock_b2_data",   o_data,        64'hB2);
        i_last    = 4'b1111;
        i_data[1] = 64'hB3;
        tick();
        chk("lock_b3_stream", 64'(o_stream), 64'h1);
        chk("lock_b3_last",   64'(o_last),   64'h1);
        chk("lock_b3_data",   o_data,        64'hB3);
        chk("unlock_ready",   64'(i_ready),  64'h1);
        tick();
        chk("unlock_stream", 64'(o_stream), 64'h0);
        chk("unlock_data",   o_data,        64'h100);

        // Backpressure: A5 from stream 1 while o_ready goes 1,0,0,1.
        i_valid   = 4'b0010;
        i_data[1] = 64'hA5;
        tick();
        chk("bp_load_data",   o_data,        64'hA5);
        chk("bp_load_stream", 64'(o_stream), 64'h1);
        o_ready   = 1'b0;
        i_valid   = 4'b0001;
        i_data[0] = 64'h5A;
        #1;
        chk("bp_ready_low0", 64'(i_ready), 64'h0);
        tick();
        chk("bp_hold1_data",   o_data,        64'hA5);
        chk("bp_hold1_stream", 64'(o_stream), 64'h1);
        chk("bp_hold1_valid",  64'(o_valid),  64'h1);
        tick();
        chk("bp_hold2_data",   o_data,        64'hA5);
        chk("bp_hold2_stream", 64'(o_stream), 64'h1);
        chk("bp_ready_low1",   64'(i_ready),  64'h0);
        o_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(i_ready), 64'h1);
        tick();
        chk("bp_next_data",   o_data,        64'h5A);
        chk("bp_next_stream", 64'(o_stream), 64'h0);
        i_valid = 4'b0000;
        tick();
        chk("bp_no_dup_valid", 64'(o_valid), 64'h0);

        // Reset while locked on stream 2.
        i_valid   = 4'b0100;
        i_last    = 4'b1011;
        i_data[2] = 64'hC1;
        tick();
        chk("rl_stream", 64'(o_stream), 64'h2);
        chk("rl_last",   64'(o_last),   64'h0);
        i_valid = 4'b0101;
        #1;
        chk("rl_locked_ready", 64'(i_ready), 64'h4);
        rst_n = 1'b0;
        #1;
        chk("rl_async_valid", 64'(o_valid), 64'h0);
        chk("rl_async_ready", 64'(i_ready), 64'h0);
        tick();
        chk("rl_held_valid", 64'(o_valid), 64'h0);
        rst_n = 1'b1;
        #1;
        chk("rl_post_ready", 64'(i_ready), 64'h1);
        tick();
        chk("rl_post_stream", 64'(o_stream), 64'h0);
        chk("rl_post_data",   o_data,        64'h5A);
        chk("rl_post_valid",  64'(o_valid),  64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
